// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link: receiver FSM encoding and
// the parity-mode constants also used by the 4-bit parity generator.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // chk is the XOR of all data bits and the received parity bit.
    function automatic logic parity_error(input logic chk, input logic mode);
        return (mode == PAR_ODD) ? ~chk : chk;
    endfunction

endpackage

// File: rtl/parity_checker_serial_if.sv
// Bundle of the serial parity receiver's link-side and status signals.
// master = the side feeding bits, slave = the receiver.
interface parity_checker_serial_if #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                  din;
    logic                  din_valid;
    logic                  parity_mode;
    logic                  sync;
    logic                  clr_count;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_ready;
    logic                  parity_err;
    logic [CNT_WIDTH-1:0]  err_count;

    modport master (
        output din, din_valid, parity_mode, sync, clr_count,
        input  data_out, data_ready, parity_err, err_count
    );

    modport slave (
        input  din, din_valid, parity_mode, sync, clr_count,
        output data_out, data_ready, parity_err, err_count
    );
endinterface

// File: rtl/parity_checker_serial_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Reusable by any link monitor that counts events.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/parity_checker_serial.sv
// Receiver end of the serial parity link: deserialises LSB-first data plus a
// parity bit, checks even/odd parity and keeps a saturating error count.
module parity_checker_serial
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    parity_checker_serial_if.slave  link
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    state_e                state_q;
    logic [BW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  parity_err_q;
    logic                  data_ready_q;

    logic                  last_data_bit;
    logic                  frame_done;
    logic                  frame_err;

    // Write the incoming bit into the slot selected by the bit counter.
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (cnt_q == BW'(i)) begin
                shift_d[i] = link.din;
            end
        end
    end

    assign last_data_bit = (cnt_q == BW'(DATA_WIDTH - 1));
    assign frame_done    = (state_q == PARITY) && link.din_valid && !link.sync;
    assign frame_err     = parity_error((^shift_q) ^ link.din, link.parity_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            if (link.sync) begin
                // Resync drops the partial frame; a same-cycle bit starts a new one.
                if (link.din_valid) begin
                    state_q <= DATA;
                    cnt_q   <= BW'(1);
                    shift_q <= DATA_WIDTH'(link.din);
                end else begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            end else if (link.din_valid) begin
                case (state_q)
                    IDLE: begin
                        state_q <= DATA;
                        cnt_q   <= BW'(1);
                        shift_q <= DATA_WIDTH'(link.din);
                    end
                    DATA: begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (last_data_bit) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        data_out_q   <= shift_q;
                        parity_err_q <= frame_err;
                        data_ready_q <= 1'b1;
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (frame_done && frame_err),
        .clr_i   (link.clr_count),
        .count_o (link.err_count)
    );

    assign link.data_out   = data_out_q;
    assign link.parity_err = parity_err_q;
    assign link.data_ready = data_ready_q;
endmodule

// File: tb/tb_parity_checker_serial.sv
// Self-checking bench for parity_checker_serial: a scoreboard of expected
// frame results is filled as frames are sent and drained on each data_ready.
module tb_parity_checker_serial;
    import parity_pkg::*;

    localparam int DW = 4;
    localparam int CW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    parity_checker_serial_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) link ();

    parity_checker_serial #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    exp_t          sb[$];
    exp_t          mon_e;
    int            vectors     = 0;
    int            miscompares = 0;
    logic [CW-1:0] cnt_model   = '0;

    // Scoreboard drain: every data_ready must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && link.data_ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: data_ready=1 with no frame pending (data_out=%b) at %0t",
                         link.data_out, $time);
            end else begin
                mon_e = sb.pop_front();
                vectors++;
                if (link.data_out !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL data_out: got %b want %b at %0t", link.data_out, mon_e.data, $time);
                end
                vectors++;
                if (link.parity_err !== mon_e.err) begin
                    miscompares++;
                    $display("FAIL parity_err: got %b want %b at %0t", link.parity_err, mon_e.err, $time);
                end
                vectors++;
                if (link.err_count !== mon_e.cnt) begin
                    miscompares++;
                    $display("FAIL err_count: got %0d want %0d at %0t", link.err_count, mon_e.cnt, $time);
                end
            end
        end
    end

    // One clock of stimulus; returns just after the edge with strobes released.
    task automatic step(input logic v, input logic b, input logic mode,
                        input logic s = 1'b0, input logic c = 1'b0);
        link.din_valid   = v;
        link.din         = b;
        link.parity_mode = mode;
        link.sync        = s;
        link.clr_count   = c;
        @(posedge clk);
        #1;
        link.din_valid   = 1'b0;
        link.din         = 1'b0;
        link.sync        = 1'b0;
        link.clr_count   = 1'b0;
        link.parity_mode = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one full frame with gap idle cycles between its bits, predicts the
    // result and checks the single-cycle latency of data_ready.
    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic mode,
                              input int gap = 0, input logic clr = 1'b0,
                              input logic sync_first = 1'b0);
        logic err;
        for (int i = 0; i < DW; i++) begin
            if (i > 0) idle(gap);
            step(1'b1, d[i], 1'($urandom), (i == 0) ? sync_first : 1'b0);
        end
        idle(gap);
        err = ((^d) ^ par) ^ (mode == PAR_ODD);
        if (clr) cnt_model = '0;
        else if (err && cnt_model != '1) cnt_model = cnt_model + 1'b1;
        sb.push_back('{d, err, cnt_model});
        step(1'b1, par, mode, 1'b0, clr);
        @(negedge clk);
        vectors++;
        if (link.data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_latency: data_ready=%b want 1 after frame %b at %0t",
                     link.data_ready, d, $time);
        end
    endtask

    task automatic check_cleared(input string tag);
        vectors++;
        if (link.data_out !== '0) begin
            miscompares++;
            $display("FAIL %s_data_out: got %b want 0", tag, link.data_out);
        end
        vectors++;
        if (link.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_data_ready: got %b want 0", tag, link.data_ready);
        end
        vectors++;
        if (link.parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_parity_err: got %b want 0", tag, link.parity_err);
        end
        vectors++;
        if (link.err_count !== '0) begin
            miscompares++;
            $display("FAIL %s_err_count: got %0d want 0", tag, link.err_count);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        link.din         = 1'b0;
        link.din_valid   = 1'b0;
        link.parity_mode = PAR_EVEN;
        link.sync        = 1'b0;
        link.clr_count   = 1'b0;
        idle(3);
        check_cleared("reset");
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_even_ok();
        send_frame(4'b0011, 1'b0, PAR_EVEN);
        @(negedge clk);
        vectors++;
        if (link.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_width: data_ready=%b want 0 one cycle after pulse", link.data_ready);
        end
    endtask

    task automatic test_parity_modes();
        send_frame(4'b0111, 1'b0, PAR_EVEN);
        send_frame(4'b0111, 1'b0, PAR_ODD);
        send_frame(4'b1000, 1'b0, PAR_ODD);
        idle(2);
    endtask

    task automatic test_back_to_back();
        send_frame(4'b0101, 1'b0, PAR_EVEN, 3);
        send_frame(4'b1111, 1'b0, PAR_EVEN, 3);
        send_frame(4'b1010, 1'b1, PAR_EVEN, 0);
        idle(2);
    endtask

    task automatic test_sync_mid_frame();
        step(1'b1, 1'b1, 1'($urandom));
        step(1'b1, 1'b0, 1'($urandom));
        send_frame(4'b0001, 1'b1, PAR_EVEN, 0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_sync_parity();
        for (int i = 0; i < DW; i++) step(1'b1, 1'(i & 1), 1'($urandom));
        // The sync cycle is the would-be parity cycle; its bit starts a new frame.
        send_frame(4'b0011, 1'b0, PAR_EVEN, 1, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) send_frame(4'b0111, 1'b0, PAR_EVEN);
        send_frame(4'b0111, 1'b0, PAR_EVEN, 0, 1'b1);
        send_frame(4'b1110, 1'b1, PAR_ODD);
        idle(2);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'($urandom));
        rst_n = 1'b0;
        #2;
        check_cleared("async_reset");
        cnt_model = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_frame(4'b0000, 1'b0, PAR_EVEN);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_even_ok();
        test_parity_modes();
        test_back_to_back();
        test_sync_mid_frame();
        test_sync_parity();
        test_saturation();
        test_async_reset();
        idle(3);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_ready: %0d expected frames never completed", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
